// File: rtl/decode_wide_pkg.sv
// Shared types for the wide decoder: fetch/flush packets, decoded uop record and the
// RISC-V instruction decode function used by every lane.
package decode_wide_pkg;

    localparam int unsigned DECODE_MAX_LANES = 4;
    localparam int unsigned UOP_QDEPTH       = 8;

    typedef logic [$clog2(UOP_QDEPTH):0] t_uop_qidx;

    typedef enum logic [3:0] {
        U_ILLEGAL,
        U_LUI,
        U_AUIPC,
        U_JAL,
        U_JALR,
        U_BRANCH,
        U_LOAD,
        U_STORE,
        U_ADDI,
        U_ALUI,
        U_ALU,
        U_FENCE,
        U_ECALL,
        U_EBREAK,
        U_CSR
    } t_uop;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_nxt;
        logic [31:0] simid;
    } t_instr_pkt;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } t_nuke_pkt;

    typedef struct packed {
        t_uop        uop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_nxt;
        logic [31:0] simid;
    } t_uinstr;

    // pc/pc_nxt/simid are left zero; the caller copies them from the fetch packet.
    function automatic t_uinstr f_decode_rv_instr(input logic [31:0] instr);
        t_uinstr u;
        u     = '0;
        u.rd  = instr[11:7];
        u.rs1 = instr[19:15];
        u.rs2 = instr[24:20];
        case (instr[6:0])
            7'h37: begin
                u.uop = U_LUI;
                u.imm = {instr[31:12], 12'h000};
            end
            7'h17: begin
                u.uop = U_AUIPC;
                u.imm = {instr[31:12], 12'h000};
            end
            7'h6f: begin
                u.uop = U_JAL;
                u.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'h67: begin
                u.uop = U_JALR;
                u.imm = {{20{instr[31]}}, instr[31:20]};
            end
            7'h63: begin
                u.uop = U_BRANCH;
                u.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'h03: begin
                u.uop = U_LOAD;
                u.imm = {{20{instr[31]}}, instr[31:20]};
            end
            7'h23: begin
                u.uop = U_STORE;
                u.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'h13: begin
                u.uop = (instr[14:12] == 3'b000) ? U_ADDI : U_ALUI;
                u.imm = {{20{instr[31]}}, instr[31:20]};
            end
            7'h33: u.uop = U_ALU;
            7'h0f: u.uop = U_FENCE;
            7'h73: begin
                if (instr == 32'h0010_0073) begin
                    u.uop = U_EBREAK;
                end else if (instr == 32'h0000_0073) begin
                    u.uop = U_ECALL;
                end else begin
                    u.uop = U_CSR;
                end
                u.imm = {{20{instr[31]}}, instr[31:20]};
            end
            default: u.uop = U_ILLEGAL;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/decode_wide_ring.sv
// Multi-push / multi-pop circular buffer. Pointers carry one extra wrap bit so that
// full (occupancy == DEPTH) and empty are distinguishable.
module uop_ring #(
    parameter type         T     = logic,
    parameter int unsigned NPUSH = 2,
    parameter int unsigned NPOP  = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned QW   = AW + 1,
    localparam int unsigned PSW  = $clog2(NPUSH + 1),
    localparam int unsigned POW  = $clog2(NPOP + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic [PSW-1:0] push_cnt_i,
    input  T               push_data_i [NPUSH],
    input  logic [POW-1:0] pop_cnt_i,
    output logic [QW-1:0]  free_o,
    output logic [QW-1:0]  occ_o,
    output T               dout_o [NPOP]
);

    T              mem_q [DEPTH];
    logic [QW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full;

    assign occ_o  = wr_ptr_q - rd_ptr_q;
    assign free_o = QW'(DEPTH) - occ_o;
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    always_comb begin
        for (int unsigned i = 0; i < NPOP; i++) begin
            dout_o[i] = mem_q[rd_ptr_q[AW-1:0] + AW'(i)];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + QW'(push_cnt_i);
        rd_ptr_d = rd_ptr_q + QW'(pop_cnt_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NPUSH; i++) begin
                if (i < 32'(push_cnt_i)) begin
                    mem_q[wr_ptr_q[AW-1:0] + AW'(i)] <= push_data_i[i];
                end
            end
        end
    end

    a_full_occ: assert property (@(posedge clk_i) disable iff (!rst_ni)
        full |-> (occ_o == QW'(DEPTH)));

endmodule

// File: rtl/decode_wide.sv
// N-wide decode stage: decodes up to NDEC fetched instructions per cycle into a uop queue
// and pops up to NPOP uops per cycle to ucode under credit backpressure.
module decode_wide
    import decode_wide_pkg::*;
#(
    parameter int unsigned NDEC  = 2,
    parameter int unsigned NPOP  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNTW  = 32,
    localparam int unsigned CRW  = $clog2(NPOP + 1),
    localparam int unsigned PW   = $clog2(NDEC + 1),
    localparam int unsigned QW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  t_nuke_pkt        nuke_rb1,
    input  logic [NDEC-1:0]  valid_fe1,
    input  t_instr_pkt       instr_fe1 [NDEC],
    output logic             decode_ready_de0,
    input  logic [CRW-1:0]   ucode_credits_uc0,
    output logic [NPOP-1:0]  valid_de1,
    output t_uinstr          uinstr_de1 [NPOP],
    output logic [CNTW-1:0]  stall_cycles
);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < NDEC) || (NDEC > DECODE_MAX_LANES)
        || (NPOP > DECODE_MAX_LANES)) begin : g_bad_param
        $error("decode_wide: illegal NDEC/NPOP/DEPTH combination");
    end

    t_uinstr         lane_uop [NDEC];
    logic [PW-1:0]   grp_cnt;
    logic            grp_ebreak;
    logic            accept;
    logic [PW-1:0]   push_cnt;
    logic [CRW-1:0]  n_pop;
    logic [QW-1:0]   occ;
    logic [QW-1:0]   free;
    logic            ebreak_seen_q, ebreak_seen_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic [NDEC-1:0] vfe_inc;
    logic            unused_nuke_pc;

    assign unused_nuke_pc = ^nuke_rb1.pc;

    always_comb begin
        for (int unsigned i = 0; i < NDEC; i++) begin
            lane_uop[i]        = f_decode_rv_instr(instr_fe1[i].instr);
            lane_uop[i].pc     = instr_fe1[i].pc;
            lane_uop[i].pc_nxt = instr_fe1[i].pc_nxt;
            lane_uop[i].simid  = instr_fe1[i].simid;
        end
    end

    // Count lanes up to and including the first ebreak; later lanes are dropped.
    always_comb begin
        grp_cnt    = '0;
        grp_ebreak = 1'b0;
        for (int unsigned i = 0; i < NDEC; i++) begin
            if (valid_fe1[i] && !grp_ebreak) begin
                grp_cnt    = grp_cnt + PW'(1);
                grp_ebreak = (lane_uop[i].uop == U_EBREAK);
            end
        end
    end

    assign decode_ready_de0 = (free >= QW'(NDEC)) && !ebreak_seen_q && reset_n;
    assign accept           = (|valid_fe1) && decode_ready_de0 && !nuke_rb1.valid;
    assign push_cnt         = accept ? grp_cnt : '0;

    always_comb begin
        if (32'(occ) < 32'(ucode_credits_uc0)) begin
            n_pop = CRW'(occ);
        end else begin
            n_pop = ucode_credits_uc0;
        end
        for (int unsigned i = 0; i < NPOP; i++) begin
            valid_de1[i] = (32'(n_pop) > i);
        end
    end

    uop_ring #(
        .T     (t_uinstr),
        .NPUSH (NDEC),
        .NPOP  (NPOP),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .flush_i     (nuke_rb1.valid),
        .push_cnt_i  (push_cnt),
        .push_data_i (lane_uop),
        .pop_cnt_i   (n_pop),
        .free_o      (free),
        .occ_o       (occ),
        .dout_o      (uinstr_de1)
    );

    always_comb begin
        ebreak_seen_d = ebreak_seen_q || (accept && grp_ebreak);
        if (nuke_rb1.valid) begin
            ebreak_seen_d = 1'b0;
        end
        stall_d = stall_q;
        if ((occ != '0) && (ucode_credits_uc0 == '0) && !(&stall_q)) begin
            stall_d = stall_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ebreak_seen_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            ebreak_seen_q <= ebreak_seen_d;
            stall_q       <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

    assign vfe_inc = valid_fe1 + NDEC'(1);

    a_valid_prefix: assert property (@(posedge clk) disable iff (!reset_n)
        (vfe_inc & valid_fe1) == '0);
    a_credit_range: assert property (@(posedge clk) disable iff (!reset_n)
        32'(ucode_credits_uc0) <= NPOP);
    a_push_ready: assert property (@(posedge clk) disable iff (!reset_n)
        (push_cnt != '0) |-> decode_ready_de0);
    a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
        32'(occ) <= DEPTH);

endmodule

// File: tb/tb_decode_wide.sv
// Directed bench for decode_wide: group push, ordered/wrapping pop, ebreak truncation,
// nuke, async reset, free-space boundary and stall-counter saturation.
module tb_decode_wide;
    import decode_wide_pkg::*;

    localparam int unsigned NDEC  = 2;
    localparam int unsigned NPOP  = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNTW  = 4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic            clk = 1'b0;
    logic            reset_n;
    t_nuke_pkt       nuke_rb1;
    logic [NDEC-1:0] valid_fe1;
    t_instr_pkt      instr_fe1 [NDEC];
    logic            decode_ready_de0;
    logic [1:0]      ucode_credits_uc0;
    logic [NPOP-1:0] valid_de1;
    t_uinstr         uinstr_de1 [NPOP];
    logic [CNTW-1:0] stall_cycles;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_ctr;
    logic [31:0] ebreak_pc;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    decode_wide #(
        .NDEC  (NDEC),
        .NPOP  (NPOP),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .nuke_rb1          (nuke_rb1),
        .valid_fe1         (valid_fe1),
        .instr_fe1         (instr_fe1),
        .decode_ready_de0  (decode_ready_de0),
        .ucode_credits_uc0 (ucode_credits_uc0),
        .valid_de1         (valid_de1),
        .uinstr_de1        (uinstr_de1),
        .stall_cycles      (stall_cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_fe1         = '0;
        nuke_rb1          = '0;
        ucode_credits_uc0 = 2'd0;
    endtask

    task automatic present(input logic [1:0] vld, input logic [31:0] i0, input logic [31:0] i1);
        valid_fe1             = vld;
        instr_fe1[0].instr    = i0;
        instr_fe1[0].pc       = pc_ctr;
        instr_fe1[0].pc_nxt   = pc_ctr + 32'd4;
        instr_fe1[0].simid    = pc_ctr >> 2;
        instr_fe1[1].instr    = i1;
        instr_fe1[1].pc       = pc_ctr + 32'd4;
        instr_fe1[1].pc_nxt   = pc_ctr + 32'd8;
        instr_fe1[1].simid    = (pc_ctr + 32'd4) >> 2;
    endtask

    // Record the pcs the bench expects to be queued from the presented group.
    task automatic commit(input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back(pc_ctr + 32'(4 * k));
        end
        pc_ctr = pc_ctr + 32'd8;
    endtask

    task automatic pop_check(input string tag, input int n);
        logic [31:0] e;
        check_eq({tag, ".valid"}, 64'(valid_de1), (64'd1 << n) - 64'd1);
        for (int k = 0; k < n; k++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 32'hdead_beef;
            check_eq({tag, ".pc"}, 64'(uinstr_de1[k].pc), 64'(e));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pc_ctr  = 32'h0000_1000;
        idle();
        present(2'b00, 32'd0, 32'd0);
        #2;
        check_eq("rst.ready", 64'(decode_ready_de0), 64'd0);
        check_eq("rst.valid", 64'(valid_de1), 64'd0);
        check_eq("rst.upc", 64'(uinstr_de1[0].pc), 64'd0);
        check_eq("rst.uop", 64'(uinstr_de1[0].uop), 64'd0);
        check_eq("rst.stall", 64'(stall_cycles), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check_eq("rel.ready", 64'(decode_ready_de0), 64'd1);

        // Full-group push with zero credits.
        for (int c = 0; c < 4; c++) begin
            present(2'b11, (c == 0) ? addi(5'd1, 12'h801) : addi(5'd2, 12'(c)), addi(5'd3, 12'h010));
            commit(2);
            #1;
            check_eq("full.ready", 64'(decode_ready_de0), 64'd1);
            tick();
        end
        idle();
        ucode_credits_uc0 = 2'd2;
        #1;
        check_eq("full.occ", 64'(dut.occ), 64'd8);
        check_eq("full.ready_lo", 64'(decode_ready_de0), 64'd0);
        check_eq("full.stall", 64'(stall_cycles), 64'd3);
        check_eq("dec.uop", 64'(uinstr_de1[0].uop), 64'(U_ADDI));
        check_eq("dec.imm", 64'(uinstr_de1[0].imm), 64'hFFFF_F801);
        check_eq("dec.pcnxt", 64'(uinstr_de1[0].pc_nxt), 64'h1004);
        pop_check("drain0", 2);
        tick();
        #1;
        pop_check("drain1", 2);
        tick();
        #1;
        pop_check("drain2", 2);
        tick();

        // Refill across the wrap point, then ordered pop 11,11,01.
        ucode_credits_uc0 = 2'd0;
        present(2'b11, addi(5'd4, 12'h004), addi(5'd5, 12'h005));
        commit(2);
        #1;
        check_eq("wrap.ready0", 64'(decode_ready_de0), 64'd1);
        tick();
        present(2'b01, addi(5'd6, 12'h006), 32'd0);
        commit(1);
        #1;
        check_eq("wrap.ready1", 64'(decode_ready_de0), 64'd1);
        tick();
        idle();
        ucode_credits_uc0 = 2'd2;
        #1;
        check_eq("pop.occ", 64'(dut.occ), 64'd5);
        check_eq("pop.stall", 64'(stall_cycles), 64'd5);
        pop_check("pop0", 2);
        tick();
        #1;
        pop_check("pop1", 2);
        tick();
        #1;
        pop_check("pop2", 1);
        tick();

        // Ebreak in lane 0 truncates lane 1 and blocks decode until nuke.
        idle();
        present(2'b11, EBREAK, addi(5'd7, 12'h007));
        ebreak_pc = pc_ctr;
        commit(1);
        #1;
        check_eq("ebk.ready_pre", 64'(decode_ready_de0), 64'd1);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("ebk.ready", 64'(decode_ready_de0), 64'd0);
            check_eq("ebk.occ", 64'(dut.occ), 64'd1);
            check_eq("ebk.uop", 64'(uinstr_de1[0].uop), 64'(U_EBREAK));
            check_eq("ebk.pc", 64'(uinstr_de1[0].pc), 64'(ebreak_pc));
            tick();
        end
        nuke_rb1.valid = 1'b1;
        #1;
        check_eq("ebk.ready_nuke", 64'(decode_ready_de0), 64'd0);
        tick();
        sb.delete();
        idle();
        ucode_credits_uc0 = 2'd2;
        #1;
        check_eq("ebk.ready_post", 64'(decode_ready_de0), 64'd1);
        check_eq("ebk.occ_post", 64'(dut.occ), 64'd0);
        check_eq("ebk.valid_post", 64'(valid_de1), 64'd0);
        check_eq("ebk.stall", 64'(stall_cycles), 64'd9);
        tick();

        // Nuke with a simultaneous push attempt and a single pop.
        idle();
        present(2'b11, addi(5'd8, 12'h008), addi(5'd9, 12'h009));
        commit(2);
        tick();
        present(2'b01, addi(5'd10, 12'h00a), 32'd0);
        commit(1);
        tick();
        present(2'b11, addi(5'd11, 12'h00b), addi(5'd12, 12'h00c));
        ucode_credits_uc0 = 2'd1;
        nuke_rb1.valid    = 1'b1;
        #1;
        check_eq("nk.ready", 64'(decode_ready_de0), 64'd1);
        pop_check("nk.pop", 1);
        tick();
        sb.delete();
        idle();
        ucode_credits_uc0 = 2'd2;
        #1;
        check_eq("nk.occ", 64'(dut.occ), 64'd0);
        check_eq("nk.valid", 64'(valid_de1), 64'd0);
        check_eq("nk.stall", 64'(stall_cycles), 64'd10);
        tick();

        // Async reset with six entries queued.
        idle();
        for (int c = 0; c < 3; c++) begin
            present(2'b11, addi(5'd13, 12'(c)), addi(5'd14, 12'(c)));
            commit(2);
            tick();
        end
        idle();
        ucode_credits_uc0 = 2'd2;
        #1;
        check_eq("ar.occ", 64'(dut.occ), 64'd6);
        check_eq("ar.stall_pre", 64'(stall_cycles), 64'd12);
        pop_check("ar.pop", 2);
        reset_n = 1'b0;
        #1;
        check_eq("ar.valid", 64'(valid_de1), 64'd0);
        check_eq("ar.ready", 64'(decode_ready_de0), 64'd0);
        check_eq("ar.upc", 64'(uinstr_de1[0].pc), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        #1;
        check_eq("ar.ready_rel", 64'(decode_ready_de0), 64'd1);
        check_eq("ar.occ_rel", 64'(dut.occ), 64'd0);
        check_eq("ar.stall_rel", 64'(stall_cycles), 64'd0);
        check_eq("ar.valid_rel", 64'(valid_de1), 64'd0);
        tick();

        // Occupancy 7: a one-lane group waits for a pop to open two slots.
        idle();
        for (int c = 0; c < 3; c++) begin
            present(2'b11, addi(5'd15, 12'(c)), addi(5'd16, 12'(c)));
            commit(2);
            tick();
        end
        present(2'b01, addi(5'd17, 12'h011), 32'd0);
        commit(1);
        tick();
        present(2'b01, addi(5'd18, 12'h012), 32'd0);
        #1;
        check_eq("bnd.ready", 64'(decode_ready_de0), 64'd0);
        check_eq("bnd.occ", 64'(dut.occ), 64'd7);
        tick();
        ucode_credits_uc0 = 2'd1;
        #1;
        check_eq("bnd.occ_held", 64'(dut.occ), 64'd7);
        check_eq("bnd.ready_pop", 64'(decode_ready_de0), 64'd0);
        pop_check("bnd.pop", 1);
        tick();
        ucode_credits_uc0 = 2'd0;
        #1;
        check_eq("bnd.ready_open", 64'(decode_ready_de0), 64'd1);
        check_eq("bnd.occ6", 64'(dut.occ), 64'd6);
        commit(1);
        tick();
        idle();
        ucode_credits_uc0 = 2'd2;
        #1;
        check_eq("bnd.occ7", 64'(dut.occ), 64'd7);
        check_eq("bnd.stall", 64'(stall_cycles), 64'd5);
        for (int c = 0; c < 4; c++) begin
            pop_check("bnd.drain", (c == 3) ? 1 : 2);
            tick();
            #1;
        end
        check_eq("bnd.empty", 64'(dut.occ), 64'd0);

        // Stall counter saturates instead of wrapping.
        idle();
        present(2'b11, addi(5'd19, 12'h013), addi(5'd20, 12'h014));
        commit(2);
        tick();
        idle();
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        check_eq("sat.reach", 64'(stall_cycles), 64'd15);
        tick();
        tick();
        check_eq("sat.hold", 64'(stall_cycles), 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
